// File: rtl/wb_port_arbiter_if.sv
// Writeback request bus: per-source valid/rd/data in, one-hot ready back.
// master = writeback sources, slave = the arbiter.
interface wb_port_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*5-1:0]  req_rd;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter, fixed priority (index 0 first); WBARB_STARVE_GUARD_EN adds starvation override.
// Latency: grant is combinational, accepted write drives we6/rdaddr6/wb6 on the next cycle.
// Backpressure: hold/flush/rst drop all readies; losing sources stall in place, nothing is buffered.
module wb_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_port_arbiter_if.slave         wb,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     we6,
    output logic [4:0]               rdaddr6,
    output logic [31:0]              wb6,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic [CNT_W-1:0]         stat_conflicts
);
    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || CNT_W < 1 || MAX_WAIT < 1) begin : g_bad_param
        $error("wb_port_arbiter: illegal parameter set");
    end

    logic [NREQ-1:0] starved;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] gnt;
    logic [GW-1:0]   gnt_idx;
    logic [4:0]      sel_rd;
    logic [31:0]     sel_dat;
    logic            found;
    logic            xfer;
    logic            multi_req;

`ifdef WBARB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt [NREQ];

    always_comb begin
        starved = '0;
        for (int i = 0; i < NREQ; i++) begin
            starved[i] = wb.req_valid[i] && (wait_cnt[i] == WW'(MAX_WAIT));
        end
    end

    // Counters freeze on hold so a stalled pipeline doesn't manufacture starvation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
        end else if (!hold) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!wb.req_valid[i] || gnt[i])
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WW'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + WW'(1);
            end
        end
    end
`else
    assign starved = '0;
`endif

    // Starved sources, if any, form the candidate set; lowest index wins within it.
    always_comb begin
        cand    = (|starved) ? starved : wb.req_valid;
        gnt     = '0;
        gnt_idx = '0;
        sel_rd  = '0;
        sel_dat = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && cand[i]) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = GW'(i);
                sel_rd  = wb.req_rd[5*i +: 5];
                sel_dat = wb.req_data[32*i +: 32];
            end
        end
        if (rst || hold || flush) gnt = '0;
    end

    assign wb.req_ready = gnt;
    assign xfer         = |gnt;
    assign multi_req    = |(wb.req_valid & (wb.req_valid - NREQ'(1)));

    // Writes to x0 complete the handshake but never assert we6 or disturb wb6.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we6      <= 1'b0;
            rdaddr6  <= '0;
            wb6      <= '0;
            grant_id <= '0;
        end else begin
            we6 <= 1'b0;
            if (xfer) begin
                we6      <= (sel_rd != 5'd0);
                rdaddr6  <= sel_rd;
                grant_id <= gnt_idx;
                if (sel_rd != 5'd0) wb6 <= sel_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stat_conflicts <= '0;
        else if (multi_req && !hold && !flush && (stat_conflicts != '1))
            stat_conflicts <= stat_conflicts + CNT_W'(1);
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized + directed bench for wb_port_arbiter against a cycle-level reference model.
// Build with +define+WBARB_STARVE_GUARD_EN to exercise the starvation override.
module tb_wb_port_arbiter;
    localparam int NREQ     = 4;
    localparam int CNT_W    = 5;
    localparam int MAX_WAIT = 4;
    localparam int STAT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic              flush;
    logic              we6;
    logic [4:0]        rdaddr6;
    logic [31:0]       wb6;
    logic [1:0]        grant_id;
    logic [CNT_W-1:0]  stat_conflicts;

    logic [NREQ-1:0]   sv;
    logic [4:0]        srd  [NREQ];
    logic [31:0]       sdat [NREQ];

    int n_chk  = 0;
    int n_pass = 0;

    wb_port_arbiter_if #(.NREQ(NREQ)) ifc ();

    assign ifc.req_valid = sv;

    for (genvar i = 0; i < NREQ; i++) begin : g_src
        assign ifc.req_rd[5*i +: 5]    = srd[i];
        assign ifc.req_data[32*i +: 32] = sdat[i];

        a_stable: assert property (@(posedge clk) disable iff (rst)
            (sv[i] && !ifc.req_ready[i]) |=> (sv[i] && $stable(srd[i]) && $stable(sdat[i])))
            else $error("FAIL src_stable[%0d]: request dropped or changed before acceptance", i);
    end

    wb_port_arbiter #(
        .NREQ     (NREQ),
        .CNT_W    (CNT_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb             (ifc),
        .hold           (hold),
        .flush          (flush),
        .we6            (we6),
        .rdaddr6        (rdaddr6),
        .wb6            (wb6),
        .grant_id       (grant_id),
        .stat_conflicts (stat_conflicts)
    );

    always #5 clk = ~clk;

    // Reference model state: what the write port should show this cycle.
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wb;
    int          exp_gid;
    int          exp_stat;
`ifdef WBARB_STARVE_GUARD_EN
    int          wcnt [NREQ];
`endif

    logic [NREQ-1:0] samp_rdy;
    logic            samp_we;
    logic [4:0]      samp_rd;
    logic [31:0]     samp_wb;
    logic [1:0]      samp_gid;
    logic [CNT_W-1:0] samp_stat;
    int              last_g;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_we   = 1'b0;
        exp_rd   = '0;
        exp_wb   = '0;
        exp_gid  = 0;
        exp_stat = 0;
`ifdef WBARB_STARVE_GUARD_EN
        for (int i = 0; i < NREQ; i++) wcnt[i] = 0;
`endif
    endtask

    function automatic int pick();
        if (rst || hold || flush) return -1;
`ifdef WBARB_STARVE_GUARD_EN
        for (int i = 0; i < NREQ; i++) if (sv[i] && wcnt[i] == MAX_WAIT) return i;
`endif
        for (int i = 0; i < NREQ; i++) if (sv[i]) return i;
        return -1;
    endfunction

    // One clock: sample/check at negedge, advance the model at posedge, return at posedge+1.
    task automatic cyc();
        int g;
        int nv;
        @(negedge clk);
        g         = pick();
        samp_rdy  = ifc.req_ready;
        samp_we   = we6;
        samp_rd   = rdaddr6;
        samp_wb   = wb6;
        samp_gid  = grant_id;
        samp_stat = stat_conflicts;
        check("req_ready", samp_rdy, (g < 0) ? 0 : (1 << g));
        check("we6", samp_we, exp_we);
        check("rdaddr6", samp_rd, exp_rd);
        check("wb6", samp_wb, exp_wb);
        check("grant_id", samp_gid, exp_gid);
        check("stat_conflicts", samp_stat, exp_stat);
        nv = $countones(sv);
        @(posedge clk);
        if (g >= 0) begin
            exp_we  = (srd[g] != 5'd0);
            exp_rd  = srd[g];
            exp_gid = g;
            if (srd[g] != 5'd0) exp_wb = sdat[g];
        end else begin
            exp_we = 1'b0;
        end
        if (nv >= 2 && !hold && !flush && exp_stat < STAT_MAX) exp_stat++;
`ifdef WBARB_STARVE_GUARD_EN
        for (int i = 0; i < NREQ; i++) begin
            if (flush)                 wcnt[i] = 0;
            else if (hold)             wcnt[i] = wcnt[i];
            else if (!sv[i] || i == g) wcnt[i] = 0;
            else if (wcnt[i] < MAX_WAIT) wcnt[i]++;
        end
`endif
        last_g = g;
        #1;
    endtask

    task automatic drain();
        hold  = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 24 && sv != '0; k++) begin
            cyc();
            if (last_g >= 0) sv[last_g] = 1'b0;
        end
        check("drain_empty", sv, 0);
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] dat);
        sv[i]   = 1'b1;
        srd[i]  = rd;
        sdat[i] = dat;
    endtask

    initial begin
        int g3;
        logic [NREQ-1:0] rdy5;

        rst   = 1'b1;
        hold  = 1'b0;
        flush = 1'b0;
        sv    = '0;
        for (int i = 0; i < NREQ; i++) begin
            srd[i]  = '0;
            sdat[i] = '0;
        end
        model_reset();
        last_g = -1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ifc.req_ready, 0);
        check("rst_we6", we6, 0);
        check("rst_stat", stat_conflicts, 0);
        rst = 1'b0;

        // Two-way contention: req0 first, req2 next cycle.
        set_src(0, 5'd5, 32'hAAAA0000);
        set_src(2, 5'd7, 32'h0000BBBB);
        cyc();
        check("t2_rdy_c0", samp_rdy, 4'b0001);
        sv[0] = 1'b0;
        cyc();
        check("t2_we_c1", samp_we, 1);
        check("t2_rd_c1", samp_rd, 5);
        check("t2_wb_c1", samp_wb, 32'hAAAA0000);
        check("t2_rdy_c1", samp_rdy, 4'b0100);
        sv[2] = 1'b0;
        cyc();
        check("t2_rd_c2", samp_rd, 7);
        check("t2_wb_c2", samp_wb, 32'h0000BBBB);
        check("t2_gid_c2", samp_gid, 2);
        check("t2_stat", samp_stat, 1);

        // Write to x0.
        set_src(1, 5'd0, 32'hDEADBEEF);
        cyc();
        check("t3_rdy", samp_rdy, 4'b0010);
        sv[1] = 1'b0;
        cyc();
        check("t3_we", samp_we, 0);
        check("t3_rd", samp_rd, 0);
        check("t3_wb_hold", samp_wb, 32'h0000BBBB);
        check("t3_gid", samp_gid, 1);

        // Hold for three cycles.
        set_src(3, 5'd9, 32'h12345678);
        hold = 1'b1;
        repeat (3) begin
            cyc();
            check("t4_rdy_hold", samp_rdy, 0);
            check("t4_we_hold", samp_we, 0);
        end
        hold = 1'b0;
        cyc();
        check("t4_rdy_rel", samp_rdy, 4'b1000);
        sv[3] = 1'b0;
        cyc();
        check("t4_we", samp_we, 1);
        check("t4_wb", samp_wb, 32'h12345678);
        check("t4_gid", samp_gid, 3);

        // One-cycle flush.
        set_src(0, 5'd3, 32'hCAFE0001);
        flush = 1'b1;
        cyc();
        check("t5_rdy_flush", samp_rdy, 0);
        flush = 1'b0;
        cyc();
        check("t5_we", samp_we, 0);
        check("t5_rdy", samp_rdy, 4'b0001);
        sv[0] = 1'b0;
        cyc();
        check("t5_wb", samp_wb, 32'hCAFE0001);

        // Starvation: req0 always refilled, req3 waiting.
        cyc();
        set_src(3, 5'd11, 32'h33330003);
        set_src(0, 5'd1, $urandom);
        g3   = -1;
        rdy5 = '0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (c == 5) rdy5 = samp_rdy;
            if (samp_rdy[3] && g3 < 0) g3 = c;
            if (last_g == 3) sv[3] = 1'b0;
            if (last_g == 0) set_src(0, 5'(1 + (c % 30)), $urandom);
        end
`ifdef WBARB_STARVE_GUARD_EN
        check("t6_req3_grant_cycle", g3, 4);
`else
        check("t6_req3_grant_cycle", g3, -1);
`endif
        check("t6_rdy_c5", rdy5, 4'b0001);
        drain();

        // Random traffic with a mid-stream reset.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                rst = 1'b1;
                #1;
                check("t1_rst_ready", ifc.req_ready, 0);
                check("t1_rst_we6", we6, 0);
                check("t1_rst_rd", rdaddr6, 0);
                check("t1_rst_wb", wb6, 0);
                check("t1_rst_gid", grant_id, 0);
                check("t1_rst_stat", stat_conflicts, 0);
                @(posedge clk);
                #1;
                sv = '0;
                rst = 1'b0;
                model_reset();
            end
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!sv[i] && $urandom_range(0, 2) != 0)
                    set_src(i, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom);
            end
            cyc();
            if (last_g >= 0) sv[last_g] = 1'b0;
        end
        drain();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
